// File: rtl/red_pitaya_exp_debounce_if.sv
// System-bus register port of the expansion debouncer: one-cycle strobes with a
// registered acknowledge and read data.
interface red_pitaya_exp_debounce_if;
  logic [31:0] sys_addr;
  logic [31:0] sys_wdata;
  logic        sys_wen;
  logic        sys_ren;
  logic [31:0] sys_rdata;
  logic        sys_err;
  logic        sys_ack;

  modport master (
    output sys_addr, sys_wdata, sys_wen, sys_ren,
    input  sys_rdata, sys_err, sys_ack
  );

  modport slave (
    input  sys_addr, sys_wdata, sys_wen, sys_ren,
    output sys_rdata, sys_err, sys_ack
  );
endinterface

// File: rtl/red_pitaya_exp_debounce.sv
// Expansion-connector input conditioner: 2-FF synchronisers, per-bit debounce,
// sticky W1C edge flags, maskable level interrupt and a small register window.
module red_pitaya_exp_debounce #(
  parameter int             DWE = 8,
  parameter int             DBW = 16,
  parameter logic [DBW-1:0] DBC = 16'd1250
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic [DWE-1:0]              exp_p_pad_i,
  input  logic [DWE-1:0]              exp_n_pad_i,
  output logic [DWE-1:0]              exp_p_dat_o,
  output logic [DWE-1:0]              exp_n_dat_o,
  output logic                        irq_o,
  red_pitaya_exp_debounce_if.slave    bus
);

  localparam int NB = 2 * DWE;

  // Both sides share one bit vector: P in the low half, N in the high half.
  logic [NB-1:0]  pad;
  logic [NB-1:0]  sync_p0;
  logic [NB-1:0]  sync_p1;
  logic [NB-1:0]  dat;
  logic [NB-1:0]  upd;
  logic [NB-1:0]  rise;
  logic [NB-1:0]  fall;
  logic [DBW-1:0] cnt [NB];
  logic [DBW-1:0] cfg;
  logic [DBW-1:0] neff;

  logic [DWE-1:0] p_rise, p_fall, n_rise, n_fall, p_ien, n_ien;
  logic [DWE-1:0] clr_p_rise, clr_p_fall, clr_n_rise, clr_n_fall;
  logic [19:0]    addr;
  logic [31:0]    rd_mux;
  logic [31:0]    rdata_p0;
  logic           ack_p0;
  logic           unused_bits;

  function automatic logic [DBW-1:0] eff_len(input logic [DBW-1:0] n);
    return (n == '0) ? {{(DBW-1){1'b0}}, 1'b1} : n;
  endfunction

  function automatic logic [DWE-1:0] w1c(input logic [DWE-1:0] flag,
                                         input logic [DWE-1:0] clr,
                                         input logic [DWE-1:0] set);
    return (flag & ~clr) | set;
  endfunction

  assign pad  = {exp_n_pad_i, exp_p_pad_i};
  assign neff = eff_len(cfg);
  assign addr = bus.sys_addr[19:0];

  // The compare is widened by one bit so cnt+1 can never wrap.
  always_comb begin
    for (int i = 0; i < NB; i++) begin
      upd[i] = (sync_p1[i] != dat[i]) &&
               (({1'b0, cnt[i]} + {{DBW{1'b0}}, 1'b1}) >= {1'b0, neff});
    end
  end

  assign rise = upd & sync_p1;
  assign fall = upd & ~sync_p1;

  // Stage p0/p1: synchroniser; then debounce state.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      dat     <= '0;
      for (int i = 0; i < NB; i++) cnt[i] <= '0;
    end else begin
      sync_p0 <= pad;
      sync_p1 <= sync_p0;
      dat     <= (dat & ~upd) | (sync_p1 & upd);
      for (int i = 0; i < NB; i++) begin
        if ((sync_p1[i] == dat[i]) || upd[i]) cnt[i] <= '0;
        else                                   cnt[i] <= cnt[i] + {{(DBW-1){1'b0}}, 1'b1};
      end
    end
  end

  assign clr_p_rise = (bus.sys_wen && addr == 20'h04) ? bus.sys_wdata[DWE-1:0] : '0;
  assign clr_p_fall = (bus.sys_wen && addr == 20'h08) ? bus.sys_wdata[DWE-1:0] : '0;
  assign clr_n_rise = (bus.sys_wen && addr == 20'h0C) ? bus.sys_wdata[DWE-1:0] : '0;
  assign clr_n_fall = (bus.sys_wen && addr == 20'h10) ? bus.sys_wdata[DWE-1:0] : '0;

  // A flag set in the same cycle as its clear survives.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cfg    <= DBC;
      p_ien  <= '0;
      n_ien  <= '0;
      p_rise <= '0;
      p_fall <= '0;
      n_rise <= '0;
      n_fall <= '0;
      irq_o  <= 1'b0;
    end else begin
      if (bus.sys_wen && addr == 20'h00) cfg   <= bus.sys_wdata[DBW-1:0];
      if (bus.sys_wen && addr == 20'h14) p_ien <= bus.sys_wdata[DWE-1:0];
      if (bus.sys_wen && addr == 20'h18) n_ien <= bus.sys_wdata[DWE-1:0];
      p_rise <= w1c(p_rise, clr_p_rise, rise[DWE-1:0]);
      p_fall <= w1c(p_fall, clr_p_fall, fall[DWE-1:0]);
      n_rise <= w1c(n_rise, clr_n_rise, rise[NB-1:DWE]);
      n_fall <= w1c(n_fall, clr_n_fall, fall[NB-1:DWE]);
      irq_o  <= (|((p_rise | p_fall) & p_ien)) | (|((n_rise | n_fall) & n_ien));
    end
  end

  always_comb begin
    rd_mux = '0;
    case (addr)
      20'h00:  rd_mux = 32'(cfg);
      20'h04:  rd_mux = 32'(p_rise);
      20'h08:  rd_mux = 32'(p_fall);
      20'h0C:  rd_mux = 32'(n_rise);
      20'h10:  rd_mux = 32'(n_fall);
      20'h14:  rd_mux = 32'(p_ien);
      20'h18:  rd_mux = 32'(n_ien);
      20'h20:  rd_mux = 32'(sync_p1[DWE-1:0]);
      20'h24:  rd_mux = 32'(sync_p1[NB-1:DWE]);
      default: rd_mux = '0;
    endcase
  end

  // Stage p0: bus response, one cycle after the strobe.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ack_p0   <= 1'b0;
      rdata_p0 <= '0;
    end else begin
      ack_p0 <= bus.sys_wen | bus.sys_ren;
      if (bus.sys_ren) rdata_p0 <= rd_mux;
    end
  end

  assign bus.sys_ack   = ack_p0;
  assign bus.sys_rdata = rdata_p0;
  assign bus.sys_err   = 1'b0;

  assign exp_p_dat_o = dat[DWE-1:0];
  assign exp_n_dat_o = dat[NB-1:DWE];

  assign unused_bits = ^{bus.sys_addr[31:20], bus.sys_wdata[31:DBW]};

endmodule
